// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// dmem_arbiter : two-port (CPU / loader) arbiter and sequencer for shared DMEM
// Revision 1.0
// ============================================================================
module dmem_arbiter #(
   parameter int ADDR_BITS = 12,
   parameter int MAX_WAIT  = 4
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        req0,
   input  logic        we0,
   input  logic [1:0]  width0,
   input  logic [31:0] addr0,
   input  logic [31:0] wdata0,
   output logic        ack0,
   output logic [31:0] rdata0,
   output logic        err0,
   input  logic        req1,
   input  logic        we1,
   input  logic [1:0]  width1,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata1,
   output logic        ack1,
   output logic [31:0] rdata1,
   output logic        err1,
   output logic        dm_ena,
   output logic        dm_w,
   output logic        dm_r,
   output logic [1:0]  dm_width,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   input  logic [31:0] dm_rdata,
   output logic        busy,
   output logic        gnt_id
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SERVE = 2'd1,
      RESP  = 2'd2
   } state_t;

   localparam logic [2:0] WAIT_LIMIT = 3'(MAX_WAIT);

   state_t      state;
   logic [2:0]  wait_cnt;
   logic        cmd_we;
   logic        cmd_err;
   logic        strobe_ena;
   logic        strobe_w;
   logic        strobe_r;

   logic        pick1;
   logic        sel_we;
   logic [1:0]  sel_width;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic        sel_bad;

   assign pick1 = req1 && (!req0 || (wait_cnt >= WAIT_LIMIT));

   always_comb begin
      sel_we    = pick1 ? we1    : we0;
      sel_width = pick1 ? width1 : width0;
      sel_addr  = pick1 ? addr1  : addr0;
      sel_wdata = pick1 ? wdata1 : wdata0;
      sel_bad   = (sel_width == 2'b11)
               || ((sel_width == 2'b01) && sel_addr[0])
               || ((sel_width == 2'b10) && (sel_addr[1:0] != 2'b00))
               || ((sel_addr >> ADDR_BITS) != 32'd0);
   end

   // Strobes are gated by rstn so a reset edge can never commit a write.
   assign dm_ena = strobe_ena & rstn;
   assign dm_w   = strobe_w   & rstn;
   assign dm_r   = strobe_r   & rstn;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state      <= IDLE;
         wait_cnt   <= 3'd0;
         cmd_we     <= 1'b0;
         cmd_err    <= 1'b0;
         strobe_ena <= 1'b0;
         strobe_w   <= 1'b0;
         strobe_r   <= 1'b0;
         dm_width   <= 2'b00;
         dm_addr    <= 32'd0;
         dm_wdata   <= 32'd0;
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         err0       <= 1'b0;
         err1       <= 1'b0;
         rdata0     <= 32'd0;
         rdata1     <= 32'd0;
         busy       <= 1'b0;
         gnt_id     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  state      <= SERVE;
                  busy       <= 1'b1;
                  gnt_id     <= pick1;
                  cmd_we     <= sel_we;
                  cmd_err    <= sel_bad;
                  strobe_ena <= !sel_bad;
                  strobe_w   <= !sel_bad && sel_we;
                  strobe_r   <= !sel_bad && !sel_we;
                  dm_width   <= sel_bad ? 2'b00 : sel_width;
                  dm_addr    <= sel_bad ? 32'd0 : sel_addr;
                  dm_wdata   <= sel_bad ? 32'd0 : sel_wdata;
                  if (pick1) begin
                     wait_cnt <= 3'd0;
                  end else if (req1 && (wait_cnt != 3'd7)) begin
                     wait_cnt <= wait_cnt + 3'd1;
                  end
               end
            end
            SERVE: begin
               state      <= RESP;
               strobe_ena <= 1'b0;
               strobe_w   <= 1'b0;
               strobe_r   <= 1'b0;
               dm_width   <= 2'b00;
               dm_addr    <= 32'd0;
               dm_wdata   <= 32'd0;
               if (gnt_id) begin
                  ack1   <= 1'b1;
                  err1   <= cmd_err;
                  rdata1 <= (cmd_err || cmd_we) ? 32'd0 : dm_rdata;
               end else begin
                  ack0   <= 1'b1;
                  err0   <= cmd_err;
                  rdata0 <= (cmd_err || cmd_we) ? 32'd0 : dm_rdata;
               end
            end
            RESP: begin
               state  <= IDLE;
               ack0   <= 1'b0;
               ack1   <= 1'b0;
               err0   <= 1'b0;
               err1   <= 1'b0;
               rdata0 <= 32'd0;
               rdata1 <= 32'd0;
               busy   <= 1'b0;
               gnt_id <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_dmem_arbiter : randomized self-checking bench with a transaction-level model
// Revision 1.0
// ============================================================================
module tb_dmem_arbiter;
   localparam int ADDR_BITS = 12;
   localparam int MAX_WAIT  = 4;

   typedef struct packed {
      logic        we;
      logic [1:0]  width;
      logic [31:0] addr;
      logic [31:0] wdata;
   } cmd_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [1:0]  req, we;
   logic [1:0]  width [2];
   logic [31:0] addr [2];
   logic [31:0] wdata [2];
   logic        ack0, ack1, err0, err1, dm_ena, dm_w, dm_r, busy, gnt_id;
   logic [31:0] rdata0, rdata1, dm_addr, dm_wdata, dm_rdata;
   logic [1:0]  dm_width;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_BITS(ADDR_BITS), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rstn(rstn),
      .req0(req[0]), .we0(we[0]), .width0(width[0]), .addr0(addr[0]), .wdata0(wdata[0]),
      .ack0(ack0), .rdata0(rdata0), .err0(err0),
      .req1(req[1]), .we1(we[1]), .width1(width[1]), .addr1(addr[1]), .wdata1(wdata[1]),
      .ack1(ack1), .rdata1(rdata1), .err1(err1),
      .dm_ena(dm_ena), .dm_w(dm_w), .dm_r(dm_r), .dm_width(dm_width),
      .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
      .busy(busy), .gnt_id(gnt_id)
   );

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Little-endian sub-word helpers shared by the memory device and the model.
   function automatic logic [31:0] rd_ext(logic [31:0] w, logic [1:0] wd, logic [1:0] off);
      logic [31:0] s;
      s = w >> (8 * off);
      if (wd == 2'b00) return s & 32'h0000_00FF;
      if (wd == 2'b01) return s & 32'h0000_FFFF;
      return w;
   endfunction

   function automatic logic [31:0] merge(logic [31:0] w, logic [1:0] wd, logic [1:0] off,
                                         logic [31:0] d);
      logic [31:0] m;
      if (wd == 2'b10) return d;
      m = (wd == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
      m = m << (8 * off);
      return (w & ~m) | ((d << (8 * off)) & m);
   endfunction

   function automatic bit is_bad(logic [1:0] w, logic [31:0] a);
      if (w == 2'b11) return 1'b1;
      if (w == 2'b01 && (a % 2) != 0) return 1'b1;
      if (w == 2'b10 && (a % 4) != 0) return 1'b1;
      return a >= (32'd1 << ADDR_BITS);
   endfunction

   // DMEM device
   logic [31:0] dmem [1024];
   bit          mem_ready = 1'b0;
   assign dm_rdata = rd_ext(dmem[dm_addr[11:2]], dm_width, dm_addr[1:0]);
   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 1024; i++) dmem[i] <= 32'hC0DE_0000 | 32'(i);
         mem_ready <= 1'b1;
      end else if (dm_ena && dm_w) begin
         dmem[dm_addr[11:2]] <= merge(dmem[dm_addr[11:2]], dm_width, dm_addr[1:0], dm_wdata);
      end
   end

   // Requester drivers
   cmd_t q0[$], q1[$];
   int   gap_pct = 0;
   always @(posedge clk) begin
      #1;
      if (!rstn) begin
         req = 2'b00; we = 2'b00;
         width[0] = 2'b00; width[1] = 2'b00;
         addr[0] = 32'd0; addr[1] = 32'd0; wdata[0] = 32'd0; wdata[1] = 32'd0;
         q0.delete(); q1.delete();
      end else begin
         if (ack0 && req[0]) begin req[0] = 1'b0; void'(q0.pop_front()); end
         if (ack1 && req[1]) begin req[1] = 1'b0; void'(q1.pop_front()); end
         if (!req[0] && q0.size() > 0 && int'($urandom_range(0, 99)) >= gap_pct) begin
            req[0] = 1'b1; we[0] = q0[0].we; width[0] = q0[0].width;
            addr[0] = q0[0].addr; wdata[0] = q0[0].wdata;
         end
         if (!req[1] && q1.size() > 0 && int'($urandom_range(0, 99)) >= gap_pct) begin
            req[1] = 1'b1; we[1] = q1[0].we; width[1] = q1[0].width;
            addr[1] = q1[0].addr; wdata[1] = q1[0].wdata;
         end
      end
   end

   // Transaction-level model: a grant at cycle g owns the memory until g+3.
   logic [31:0] ref_mem [1024];
   bit          ref_ready = 1'b0;
   logic        rst_edge = 1'b0;
   int          cyc = 0, next_free = 0, mwait = 0;
   bit          have_cur = 1'b0;
   int          cur_p, cur_g;
   logic        cur_we, cur_err;
   logic [1:0]  cur_width;
   logic [31:0] cur_addr, cur_wdata;
   logic [1:0]  e_ack, e_err;
   logic [31:0] e_rd [2];
   logic        e_busy, e_gnt, e_ena, e_w, e_r;
   logic [1:0]  e_width;
   logic [31:0] e_addr, e_wdata;
   logic [32:0] got0[$], got1[$];
   int          gseq[$];
   int          busy_cnt = 0, ena_cnt = 0;

   always @(posedge clk) rst_edge <= !rstn;

   always @(negedge clk) begin
      if (!ref_ready) begin
         for (int i = 0; i < 1024; i++) ref_mem[i] = 32'hC0DE_0000 | 32'(i);
         ref_ready = 1'b1;
      end
      if (!rstn) begin
         chk("rst_dm_ena", 64'(dm_ena), 64'd0);
         chk("rst_dm_w", 64'(dm_w), 64'd0);
         chk("rst_dm_r", 64'(dm_r), 64'd0);
         if (rst_edge) begin
            chk("rst_acks", {62'd0, ack1, ack0}, 64'd0);
            chk("rst_errs", {62'd0, err1, err0}, 64'd0);
            chk("rst_rdata", {rdata1, rdata0}, 64'd0);
            chk("rst_dm_bus", {dm_width, dm_addr, dm_wdata}, 64'd0);
            chk("rst_busy_gnt", {62'd0, busy, gnt_id}, 64'd0);
         end
         have_cur = 1'b0; next_free = 0; mwait = 0;
      end else begin
         e_ack = 2'b00; e_err = 2'b00; e_rd[0] = 32'd0; e_rd[1] = 32'd0;
         e_busy = 1'b0; e_gnt = 1'b0; e_ena = 1'b0; e_w = 1'b0; e_r = 1'b0;
         e_width = 2'b00; e_addr = 32'd0; e_wdata = 32'd0;
         if (have_cur && cyc == cur_g + 1) begin
            e_busy = 1'b1; e_gnt = 1'(cur_p);
            if (!cur_err) begin
               e_ena = 1'b1; e_w = cur_we; e_r = !cur_we;
               e_width = cur_width; e_addr = cur_addr; e_wdata = cur_wdata;
            end
         end else if (have_cur && cyc == cur_g + 2) begin
            e_busy = 1'b1; e_gnt = 1'(cur_p);
            e_ack[cur_p] = 1'b1; e_err[cur_p] = cur_err;
            if (!cur_err && !cur_we)
               e_rd[cur_p] = rd_ext(ref_mem[cur_addr[11:2]], cur_width, cur_addr[1:0]);
            if (!cur_err && cur_we)
               ref_mem[cur_addr[11:2]] = merge(ref_mem[cur_addr[11:2]], cur_width,
                                               cur_addr[1:0], cur_wdata);
            have_cur = 1'b0;
         end
         chk("ack0", 64'(ack0), 64'(e_ack[0]));
         chk("ack1", 64'(ack1), 64'(e_ack[1]));
         chk("err0", 64'(err0), 64'(e_err[0]));
         chk("err1", 64'(err1), 64'(e_err[1]));
         chk("rdata0", 64'(rdata0), 64'(e_rd[0]));
         chk("rdata1", 64'(rdata1), 64'(e_rd[1]));
         chk("busy", 64'(busy), 64'(e_busy));
         chk("gnt_id", 64'(gnt_id), 64'(e_gnt));
         chk("dm_strobes", {61'd0, dm_ena, dm_w, dm_r}, {61'd0, e_ena, e_w, e_r});
         chk("dm_width", 64'(dm_width), 64'(e_width));
         chk("dm_addr", 64'(dm_addr), 64'(e_addr));
         chk("dm_wdata", 64'(dm_wdata), 64'(e_wdata));
         if (ack0) got0.push_back({err0, rdata0});
         if (ack1) got1.push_back({err1, rdata1});
         if (busy) busy_cnt++;
         if (dm_ena) ena_cnt++;
         if (!have_cur && cyc >= next_free && req != 2'b00) begin
            cur_p = (req[1] && (!req[0] || mwait >= MAX_WAIT)) ? 1 : 0;
            if (cur_p == 1) mwait = 0;
            else if (req[1] && mwait < 7) mwait++;
            gseq.push_back(cur_p);
            cur_we = we[cur_p]; cur_width = width[cur_p];
            cur_addr = addr[cur_p]; cur_wdata = wdata[cur_p];
            cur_err = is_bad(cur_width, cur_addr);
            cur_g = cyc; have_cur = 1'b1; next_free = cyc + 3;
         end
      end
      cyc++;
   end

   task automatic put(input int p, input logic w, input logic [1:0] wd,
                      input logic [31:0] a, input logic [31:0] d);
      cmd_t c;
      c.we = w; c.width = wd; c.addr = a; c.wdata = d;
      if (p == 0) q0.push_back(c); else q1.push_back(c);
   endtask

   task automatic drain(input int max);
      int n;
      n = 0;
      while (!(q0.size() == 0 && q1.size() == 0 && req == 2'b00 && !have_cur) && n < max) begin
         @(posedge clk);
         n++;
      end
      if (n >= max) begin
         n_chk++;
         $display("FAIL drain_timeout: still busy after %0d cycles, required idle", max);
         rstn = 1'b0;
         repeat (2) @(posedge clk);
         #1 rstn = 1'b1;
      end
      repeat (2) @(posedge clk);
   endtask

   function automatic logic [32:0] got_at(input int p, input int i);
      if (p == 0) return (i < got0.size()) ? got0[i] : 33'bx;
      return (i < got1.size()) ? got1[i] : 33'bx;
   endfunction

   function automatic int gseq_at(input int i);
      return (i < gseq.size()) ? gseq[i] : -1;
   endfunction

   function automatic cmd_t rnd_cmd();
      cmd_t c;
      int   r;
      c.we = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 99));
      c.width = (r < 5) ? 2'b11 : 2'($urandom_range(0, 2));
      r = int'($urandom_range(0, 19));
      if (r == 0)      c.addr = 32'h1000 + 32'($urandom_range(0, 255));
      else if (r == 1) c.addr = 32'h0000_0FFC;
      else             c.addr = 32'($urandom_range(0, 15)) * 4;
      if ($urandom_range(0, 9) == 0)  c.addr[1:0] = 2'($urandom_range(0, 3));
      else if (c.width == 2'b00)      c.addr[1:0] = 2'($urandom_range(0, 3));
      else if (c.width == 2'b01)      c.addr[1]   = 1'($urandom_range(0, 1));
      c.wdata = $urandom;
      return c;
   endfunction

   int exp_seq [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

   initial begin
      int   g0, g1, s, b0, e0, n;
      cmd_t c;
      rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;

      // Word write then read on port 0
      g0 = got0.size();
      put(0, 1'b1, 2'b10, 32'h10, 32'hDEAD_BEEF);
      put(0, 1'b0, 2'b10, 32'h10, 32'd0);
      drain(100);
      chk("t1_write_resp", 64'(got_at(0, g0)), 64'h0);
      chk("t1_read_resp", 64'(got_at(0, g0 + 1)), 64'hDEAD_BEEF);

      // Sub-word accesses on port 1
      g1 = got1.size();
      put(1, 1'b1, 2'b10, 32'h10, 32'h0);
      put(1, 1'b1, 2'b00, 32'h13, 32'hAA);
      put(1, 1'b1, 2'b01, 32'h10, 32'h1234);
      put(1, 1'b0, 2'b10, 32'h10, 32'h0);
      put(1, 1'b0, 2'b00, 32'h13, 32'h0);
      drain(100);
      chk("t2_word_read", 64'(got_at(1, g1 + 3)), 64'hAA00_1234);
      chk("t2_byte_read", 64'(got_at(1, g1 + 4)), 64'h0000_00AA);

      // Starvation bound with both ports requesting continuously
      s = gseq.size();
      for (int i = 0; i < 8; i++) put(0, 1'b1, 2'b10, 32'h100 + 32'(4 * i), 32'(i));
      for (int i = 0; i < 2; i++) put(1, 1'b0, 2'b10, 32'h200, 32'd0);
      drain(200);
      for (int i = 0; i < 10; i++) chk($sformatf("t3_grant_%0d", i), 64'(gseq_at(s + i)), 64'(exp_seq[i]));

      // Rejected accesses
      g0 = got0.size(); e0 = ena_cnt;
      put(0, 1'b1, 2'b10, 32'h06, 32'h1111_1111);
      put(0, 1'b1, 2'b01, 32'h03, 32'h2222_2222);
      put(0, 1'b1, 2'b11, 32'h08, 32'h3333_3333);
      put(0, 1'b1, 2'b10, 32'h1000, 32'h4444_4444);
      drain(100);
      chk("t4_no_dm_ena", 64'(ena_cnt - e0), 64'd0);
      for (int i = 0; i < 4; i++) chk($sformatf("t4_err_resp_%0d", i), 64'(got_at(0, g0 + i)), 64'h1_0000_0000);
      g0 = got0.size();
      put(0, 1'b0, 2'b10, 32'h04, 32'd0);
      put(0, 1'b0, 2'b10, 32'h00, 32'd0);
      put(0, 1'b0, 2'b10, 32'h08, 32'd0);
      drain(100);
      chk("t4_word04", 64'(got_at(0, g0)), 64'hC0DE_0001);
      chk("t4_word00", 64'(got_at(0, g0 + 1)), 64'hC0DE_0000);
      chk("t4_word08", 64'(got_at(0, g0 + 2)), 64'hC0DE_0002);

      // Simultaneous request from IDLE
      s = gseq.size(); b0 = busy_cnt;
      put(0, 1'b0, 2'b10, 32'h10, 32'd0);
      put(1, 1'b0, 2'b00, 32'h13, 32'd0);
      drain(100);
      chk("t5_first_grant", 64'(gseq_at(s)), 64'd0);
      chk("t5_second_grant", 64'(gseq_at(s + 1)), 64'd1);
      chk("t5_busy_cycles", 64'(busy_cnt - b0), 64'd4);

      // Reset while a write to 0x20 is in SERVE
      put(0, 1'b1, 2'b10, 32'h20, 32'h1122_3344);
      drain(100);
      g0 = got0.size();
      put(0, 1'b1, 2'b10, 32'h20, 32'h5566_7788);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (dm_ena !== 1'b1 && n < 20);
      chk("t6_serve_reached", 64'(dm_ena), 64'd1);
      #2 rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      chk("t6_no_ack", 64'(got0.size() - g0), 64'd0);
      put(0, 1'b0, 2'b10, 32'h20, 32'd0);
      drain(100);
      chk("t6_word20", 64'(got_at(0, g0)), 64'h1122_3344);

      // Randomized traffic on both ports
      gap_pct = 30;
      for (int i = 0; i < 150; i++) begin
         c = rnd_cmd(); q0.push_back(c);
         c = rnd_cmd(); q1.push_back(c);
      end
      drain(6000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the shared data memory. It multiplexes the CPU load/store port (port 0) and an external loader/debug port (port 1) onto the single DMEM command interface, and it is placed between the CPU/loader and DMEM. Each access is latched, checked for alignment and range, and then issued as one DMEM cycle. The read data is captured and returned with a one-cycle acknowledge. CPU normally has priority; a wait counter bounds how long the loader can be starved.

## Interface
Parameters:
- `ADDR_BITS`, default 12: byte-address bits backed by DMEM (1024 words).
- `MAX_WAIT`, default 4: number of arbitration losses port 1 tolerates before it is forced to win.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rstn`  in  1  reset; synchronous, active-low.
- `reqN`  in  1  port N request, for N in {0,1}.
- `weN`  in  1  port N write (1) / read (0).
- `widthN`  in  2  port N access width: 10 word, 01 half, 00 byte, 11 illegal.
- `addrN`  in  32  port N byte address.
- `wdataN`  in  32  port N write data; byte/half data sits in the low bits.
- `ackN`  out  1  port N access complete; one-cycle pulse.
- `rdataN`  out  32  port N read data; valid only while `ackN` is high, 0 otherwise.
- `errN`  out  1  port N access rejected; qualified by `ackN`.
- `dm_ena`, `dm_w`, `dm_r`  out  1 each  DMEM enable, write strobe and read strobe.
- `dm_width`  out  2  DMEM width; same encoding as `widthN`.
- `dm_addr`, `dm_wdata`  out  32 each  DMEM address and write data.
- `dm_rdata`  in  32  DMEM combinational read data, already zero-extended.
- `busy`  out  1  high whenever the state is not IDLE.
- `gnt_id`  out  1  port currently owning the access; 0 in IDLE.

## Operation
- FSM states are IDLE, SERVE and RESP. Reset puts the FSM in IDLE.
- **IDLE, arbitration.**
  - If only one request is high, that port wins.
  - If both are high, port 0 wins unless `wait_cnt >= MAX_WAIT`, in which case port 1 wins.
  - The winner's `we`/`width`/`addr`/`wdata` are latched into command registers and `gnt_id` is set. Next state is SERVE.
  - With no request, the FSM stays in IDLE.
- **`wait_cnt` (3 bits, saturating).**
  - Increments on each IDLE cycle in which `req1` is high and port 0 wins.
  - Clears when port 1 is granted.
  - Resets to 0.
- **Command check at latch time.** The command is flagged as an error when any of these holds:
  - width = 11;
  - half access with addr[0] = 1;
  - word access with addr[1:0] != 00;
  - addr[31:ADDR_BITS] != 0.
- **SERVE.**
  - Valid command: drive `dm_ena=1`, `dm_w=we`, `dm_r=!we` and the latched width/addr/wdata. A write commits at the end of this cycle. On a read, `dm_rdata` is registered at the end of this cycle.
  - Flagged command: all `dm_*` strobes stay 0 and the captured data is forced to 0.
  - Next state is RESP.
- **RESP.**
  - `ack[gnt_id]=1` for exactly one cycle.
  - `rdata[gnt_id]` = captured data, or 0 for writes and errors.
  - `err[gnt_id]` = error flag.
  - Next state is IDLE.
- **Requester rule.**
  - Hold `req` and all command fields stable from assertion until `ack` is seen.
  - To issue a new access, keep or reassert `req` after `ack`; that IDLE cycle re-arbitrates.
- `dm_ena`, `dm_w` and `dm_r` are ANDed with `rstn`, so no DMEM write commits on a reset edge.

## Timing
- Reset values: `ackN`=0, `errN`=0, `rdataN`=0, `dm_ena`=`dm_w`=`dm_r`=0, `dm_width`=00, `dm_addr`=0, `dm_wdata`=0, `busy`=0, `gnt_id`=0, `wait_cnt`=0.
- Latency: request sampled in IDLE at cycle t, DMEM access in cycle t+1, `ack` in cycle t+2.
  - The next grant happens no earlier than t+3.
  - Peak throughput is one access per 3 cycles.
- `dm_*` outputs are high only in SERVE; they are 0 in IDLE and RESP.
- Reset in SERVE or RESP:
  - the FSM returns to IDLE;
  - any pending `ack` is dropped;
  - the in-flight write is suppressed, because the strobes are gated by `rstn`.
- A request that arrives while `busy=1` waits; it is not lost and is arbitrated at the next IDLE.
- Both ports may be waiting for a long time: port 1 is granted after at most `MAX_WAIT` consecutive port 0 grants.

## Test plan
- **Single word write then read.** Port 0 writes 0xDEADBEEF to 0x10, then reads word 0x10. Required: `ack0` at t+2 each time, read data 0xDEADBEEF, `err0`=0.
- **Sub-word accesses.** Port 1 writes byte 0xAA to 0x13 and half 0x1234 to 0x10; then port 1 reads word 0x10. Required: 0xAA001234. A byte read of 0x13 returns 0x000000AA.
- **Starvation bound.** Both ports request continuously with `MAX_WAIT`=4. Required grant sequence: 0,0,0,0,1,0,0,0,0,1; `wait_cnt` clears after each port 1 grant.
- **Error cases.**
  - Word access to 0x06, half access to 0x03, width 11, and address 0x1000 each return `ack` with `err`=1 and `rdata`=0.
  - `dm_ena` never rises, and a following read of the affected words shows their contents unchanged.
- **Reset during SERVE of a write to 0x20.** Required: no `ack`, all outputs at their reset values, and the word at 0x20 is unchanged when read back after reset.
- **Simultaneous request from IDLE.** Port 0 wins and port 1 is served next. `busy` stays high through SERVE and RESP, and is high in both back-to-back sequences.
